// File: rtl/bp_cfg_sequencer.sv
// Boot-time configuration sequencer: walks a table of config writes and issues each
// entry to every enabled core over a valid/ready channel, one acknowledged write at a time.
module bp_cfg_sequencer #(
    parameter int num_core_p       = 2,
    parameter int num_cfg_words_p  = 8,
    parameter int cfg_addr_width_p = 16,
    parameter int cfg_data_width_p = 64,
    parameter int ack_timeout_p    = 255,
    localparam int core_id_width_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
    input  logic                                                         clk_i,
    input  logic                                                         reset_n_i,
    input  logic                                                         start_i,
    input  logic [num_core_p-1:0]                                        core_mask_i,
    input  logic [num_cfg_words_p*(cfg_addr_width_p+cfg_data_width_p)-1:0] cfg_table_i,
    output logic                                                         cfg_v_o,
    input  logic                                                         cfg_ready_i,
    output logic [core_id_width_lp-1:0]                                  cfg_core_id_o,
    output logic [cfg_addr_width_p-1:0]                                  cfg_addr_o,
    output logic [cfg_data_width_p-1:0]                                  cfg_data_o,
    input  logic                                                         cfg_ack_v_i,
    output logic                                                         busy_o,
    output logic                                                         done_o,
    output logic                                                         error_o
);

    localparam int entry_width_lp = cfg_addr_width_p + cfg_data_width_p;
    localparam int word_width_lp  = (num_cfg_words_p > 1) ? $clog2(num_cfg_words_p) : 1;
    localparam int timer_width_lp = $clog2(ack_timeout_p + 1);
    localparam logic [word_width_lp-1:0]  word_last_lp  = word_width_lp'(num_cfg_words_p - 1);
    localparam logic [timer_width_lp-1:0] timer_last_lp = timer_width_lp'(ack_timeout_p - 1);

    typedef enum logic [2:0] {IDLE, SEND, WAIT_ACK, DONE, ERROR} state_e;

    state_e                      state_r, state_n;
    logic [core_id_width_lp-1:0] core_r, core_n;
    logic [word_width_lp-1:0]    word_r, word_n;
    logic [timer_width_lp-1:0]   timer_r, timer_n;
    logic [num_core_p-1:0]       mask_r, mask_n;

    logic [core_id_width_lp-1:0] first_core, next_core;
    logic                        next_found;
    logic [entry_width_lp-1:0]   table_entries [num_cfg_words_p];
    logic [entry_width_lp-1:0]   cur_entry;
    logic                        payload_en;

    for (genvar g = 0; g < num_cfg_words_p; g++) begin : g_unpack
        assign table_entries[g] = cfg_table_i[g*entry_width_lp +: entry_width_lp];
    end

    // Descending scans so the last hit wins: lowest enabled core overall, and lowest above core_r.
    always_comb begin
        first_core = '0;
        next_core  = '0;
        next_found = 1'b0;
        for (int i = num_core_p - 1; i >= 0; i--) begin
            if (core_mask_i[i]) begin
                first_core = core_id_width_lp'(i);
            end
            if (mask_r[i] && (i > int'(core_r))) begin
                next_core  = core_id_width_lp'(i);
                next_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state_r;
        core_n  = core_r;
        word_n  = word_r;
        timer_n = timer_r;
        mask_n  = mask_r;
        case (state_r)
            IDLE, DONE, ERROR: begin
                if (start_i) begin
                    mask_n  = core_mask_i;
                    word_n  = '0;
                    timer_n = '0;
                    core_n  = first_core;
                    state_n = (|core_mask_i) ? SEND : DONE;
                end
            end
            SEND: begin
                if (cfg_ready_i) begin
                    state_n = WAIT_ACK;
                    timer_n = '0;
                end
            end
            WAIT_ACK: begin
                // An ack on the final timeout cycle still wins over the error.
                if (cfg_ack_v_i) begin
                    timer_n = '0;
                    if (word_r != word_last_lp) begin
                        word_n  = word_r + 1'b1;
                        state_n = SEND;
                    end else begin
                        word_n = '0;
                        if (next_found) begin
                            core_n  = next_core;
                            state_n = SEND;
                        end else begin
                            state_n = DONE;
                        end
                    end
                end else if (timer_r == timer_last_lp) begin
                    state_n = ERROR;
                end else begin
                    timer_n = timer_r + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= IDLE;
            core_r  <= '0;
            word_r  <= '0;
            timer_r <= '0;
            mask_r  <= '0;
        end else begin
            state_r <= state_n;
            core_r  <= core_n;
            word_r  <= word_n;
            timer_r <= timer_n;
            mask_r  <= mask_n;
        end
    end

    // Payload is shown while sending, and frozen in ERROR so the failing write can be read out.
    assign payload_en    = (state_r == SEND) || (state_r == ERROR);
    assign cur_entry     = table_entries[word_r];
    assign cfg_v_o       = (state_r == SEND);
    assign busy_o        = (state_r == SEND) || (state_r == WAIT_ACK);
    assign done_o        = (state_r == DONE);
    assign error_o       = (state_r == ERROR);
    assign cfg_core_id_o = payload_en ? core_r : '0;
    assign cfg_addr_o    = payload_en ? cur_entry[entry_width_lp-1 -: cfg_addr_width_p] : '0;
    assign cfg_data_o    = payload_en ? cur_entry[cfg_data_width_p-1:0] : '0;

endmodule

// File: tb/tb_bp_cfg_sequencer.sv
// Self-checking bench for bp_cfg_sequencer: table-driven full sequences plus
// hand-written timeout, ack-on-timeout, restart and asynchronous reset cases.
module tb_bp_cfg_sequencer;

    localparam int num_core_lp  = 2;
    localparam int num_words_lp = 8;
    localparam int addr_w_lp    = 16;
    localparam int data_w_lp    = 64;
    localparam int timeout_lp   = 4;

    logic                                            clk;
    logic                                            reset_n;
    logic                                            start;
    logic [num_core_lp-1:0]                          core_mask;
    logic [num_words_lp*(addr_w_lp+data_w_lp)-1:0]   cfg_table;
    logic                                            cfg_v;
    logic                                            cfg_ready;
    logic [0:0]                                      cfg_core_id;
    logic [addr_w_lp-1:0]                            cfg_addr;
    logic [data_w_lp-1:0]                            cfg_data;
    logic                                            ack_v;
    logic                                            busy;
    logic                                            done;
    logic                                            error;

    logic [addr_w_lp-1:0] addr_tab [num_words_lp];
    logic [data_w_lp-1:0] data_tab [num_words_lp];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [1:0] mask;
        int         stall_write;
        int         stall_len;
        int         busy_start;
        int         exp_writes;
        int         exp_done;
    } vec_t;

    vec_t vecs [6];

    bp_cfg_sequencer #(
        .num_core_p(num_core_lp),
        .num_cfg_words_p(num_words_lp),
        .cfg_addr_width_p(addr_w_lp),
        .cfg_data_width_p(data_w_lp),
        .ack_timeout_p(timeout_lp)
    ) dut (
        .clk_i(clk),
        .reset_n_i(reset_n),
        .start_i(start),
        .core_mask_i(core_mask),
        .cfg_table_i(cfg_table),
        .cfg_v_o(cfg_v),
        .cfg_ready_i(cfg_ready),
        .cfg_core_id_o(cfg_core_id),
        .cfg_addr_o(cfg_addr),
        .cfg_data_o(cfg_data),
        .cfg_ack_v_i(ack_v),
        .busy_o(busy),
        .done_o(done),
        .error_o(error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_cfg_v"}, 64'(cfg_v), 64'd0);
        check_output({tag, "_busy"}, 64'(busy), 64'd0);
        check_output({tag, "_done"}, 64'(done), 64'd0);
        check_output({tag, "_error"}, 64'(error), 64'd0);
        check_output({tag, "_core_id"}, 64'(cfg_core_id), 64'd0);
        check_output({tag, "_addr"}, 64'(cfg_addr), 64'd0);
        check_output({tag, "_data"}, cfg_data, 64'd0);
    endtask

    // Acts as the config endpoint: ready unless stalling, ack exactly one cycle after each fire.
    task automatic apply_stimulus(input vec_t v);
        int cores [$];
        int n_wr = 0;
        int stall_cnt = 0;
        int done_cyc = -1;
        int idx;
        bit fired_prev = 0;
        for (int c = 0; c < num_core_lp; c++)
            if (v.mask[c]) cores.push_back(c);
        @(negedge clk);
        cyc = 0;
        start = 1'b1;
        core_mask = v.mask;
        cfg_ready = 1'b1;
        ack_v = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            cyc = c;
            start = 1'b0;
            ack_v = fired_prev;
            fired_prev = 0;
            if (c == 1) check_output("error_cleared_on_start", 64'(error), 64'd0);
            if (c == v.busy_start) begin
                start = 1'b1;
                core_mask = 2'b00;
            end
            if (done) begin
                done_cyc = c;
                break;
            end
            if (cfg_v) begin
                if (n_wr >= v.exp_writes) begin
                    check_output("extra_write", 64'(n_wr), 64'(v.exp_writes - 1));
                end else begin
                    idx = n_wr;
                    check_output("wr_core_id", 64'(cfg_core_id), 64'(cores[idx / num_words_lp]));
                    check_output("wr_addr", 64'(cfg_addr), 64'(addr_tab[idx % num_words_lp]));
                    check_output("wr_data", cfg_data, data_tab[idx % num_words_lp]);
                end
                if (n_wr == v.stall_write && stall_cnt < v.stall_len) begin
                    cfg_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    cfg_ready = 1'b1;
                    n_wr++;
                    fired_prev = 1;
                end
            end else begin
                cfg_ready = 1'b1;
            end
        end
        ack_v = 1'b0;
        check_output("write_count", 64'(n_wr), 64'(v.exp_writes));
        check_output("done_cycle", 64'(done_cyc), 64'(v.exp_done));
        check_output("busy_after_done", 64'(busy), 64'd0);
        check_output("error_after_done", 64'(error), 64'd0);
    endtask

    initial begin
        vec_t restart_vec;
        for (int i = 0; i < num_words_lp; i++) begin
            addr_tab[i] = 16'h0100 + 16'(i * 8);
            data_tab[i] = 64'hFEED_0000_0000_0000 | (64'(i) << 16) | 64'(i * 3 + 1);
            cfg_table[i*(addr_w_lp+data_w_lp) +: (addr_w_lp+data_w_lp)] = {addr_tab[i], data_tab[i]};
        end

        vecs[0] = '{mask: 2'b00, stall_write: -1, stall_len: 0, busy_start: -1, exp_writes: 0,  exp_done: 1};
        vecs[1] = '{mask: 2'b11, stall_write: -1, stall_len: 0, busy_start: -1, exp_writes: 16, exp_done: 33};
        vecs[2] = '{mask: 2'b10, stall_write: -1, stall_len: 0, busy_start: -1, exp_writes: 8,  exp_done: 17};
        vecs[3] = '{mask: 2'b11, stall_write: 3,  stall_len: 5, busy_start: -1, exp_writes: 16, exp_done: 38};
        vecs[4] = '{mask: 2'b01, stall_write: 7,  stall_len: 2, busy_start: -1, exp_writes: 8,  exp_done: 19};
        vecs[5] = '{mask: 2'b11, stall_write: -1, stall_len: 0, busy_start: 5,  exp_writes: 16, exp_done: 33};

        reset_n = 1'b0;
        start = 1'b0;
        core_mask = '0;
        cfg_ready = 1'b1;
        ack_v = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("in_reset");
        reset_n = 1'b1;
        @(negedge clk);
        check_all_zero("after_reset");

        $display("[TB] table-driven sequences");
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(vecs[i]);
        end

        $display("[TB] ack timeout");
        @(negedge clk);
        cyc = 0;
        start = 1'b1;
        core_mask = 2'b11;
        cfg_ready = 1'b1;
        ack_v = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            cyc = c;
            start = 1'b0;
            if (c == 1) check_output("to_first_valid", 64'(cfg_v), 64'd1);
            if (c < 6) check_output("to_no_early_error", 64'(error), 64'd0);
        end
        check_output("to_error_sticky", 64'(error), 64'd1);
        check_output("to_cfg_v", 64'(cfg_v), 64'd0);
        check_output("to_busy", 64'(busy), 64'd0);
        check_output("to_done", 64'(done), 64'd0);
        check_output("to_core_id", 64'(cfg_core_id), 64'd0);
        check_output("to_addr", 64'(cfg_addr), 64'(addr_tab[0]));

        $display("[TB] restart after error");
        restart_vec = '{mask: 2'b10, stall_write: -1, stall_len: 0, busy_start: -1, exp_writes: 8, exp_done: 17};
        apply_stimulus(restart_vec);

        $display("[TB] ack on timeout cycle, then async reset");
        @(negedge clk);
        cyc = 0;
        start = 1'b1;
        core_mask = 2'b01;
        cfg_ready = 1'b1;
        ack_v = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            cyc = c;
            start = 1'b0;
            ack_v = (c == 5);
        end
        ack_v = 1'b0;
        check_output("late_ack_no_error", 64'(error), 64'd0);
        check_output("late_ack_resend", 64'(cfg_v), 64'd1);
        check_output("late_ack_next_word", 64'(cfg_addr), 64'(addr_tab[1]));
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check_output("post_reset_no_retry", 64'(cfg_v), 64'd0);
        check_output("post_reset_idle_busy", 64'(busy), 64'd0);
        check_output("post_reset_idle_done", 64'(done), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
